// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the eight-digit multiplexed display path.
//   NUM_DIGITS  : number of digits on the common-anode display
//   ANODE_OFF   : anode pattern with every digit disabled (active-low)
//   digit_idx_t : index of the digit currently being scanned
//   disp_word_t : eight packed hex nibbles, digit 0 in bits 3:0
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int NUM_DIGITS = 8;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

   typedef logic [2:0]  digit_idx_t;
   typedef logic [31:0] disp_word_t;

endpackage

// File: rtl/display_scanner_refresh_tick.sv
// ---------------------------------------------------------------------------
// refresh_tick
// Free-running prescaler producing one tick every TICK_DIV clock cycles.
// The counter runs 0..TICK_DIV-1 and tick is high while it sits at the top.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, counter returns to 0
//   tick  : single-cycle pulse, high when the counter equals TICK_DIV-1
// ---------------------------------------------------------------------------
module refresh_tick #(
   parameter int TICK_DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_pcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pcnt <= '0;
      end else if (r_pcnt == LAST) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   assign tick = (r_pcnt == LAST);

endmodule

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
// Time-multiplexed scanner for an eight-digit common-anode display. Holds a
// double-buffered 32-bit value (shadow written by load, display copy updated
// only at the end of digit 7's slot so a frame never mixes two values) and
// steps through the digits once per prescaler tick. The cycle after every
// tick all anodes are off so hex/dp can settle before the next digit lights.
//
// Optional feature: define DISP_LZB_EN for leading-zero blanking. Digits
// k>0 whose nibbles k..7 are all zero stay dark and their decimal point is
// suppressed; the mask is computed at the swap alongside the display copy.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   load       : one-cycle strobe capturing value/dp_mask into the shadow
//   value      : eight hex nibbles, nibble k drives digit k (0 = rightmost)
//   dp_mask    : bit k lights the decimal point of digit k
//   hex        : nibble of the current digit, to the seven-segment decoder
//   anode      : active-low digit enables, at most one low
//   dp         : active-low decimal point of the current digit
//   pending    : a loaded value is waiting for the frame boundary
//   frame_done : one-cycle pulse after digit 7's slot ends
// ---------------------------------------------------------------------------
module display_scanner
   import display_pkg::*;
#(
   parameter int TICK_DIV = 100_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   output logic [3:0]  hex,
   output logic [7:0]  anode,
   output logic        dp,
   output logic        pending,
   output logic        frame_done
);

`ifdef DISP_LZB_EN
   // Digit k>0 is blanked when it and every more significant nibble is zero.
   function automatic logic [NUM_DIGITS-1:0] lzb_mask(input disp_word_t val);
      logic [NUM_DIGITS-1:0] m;
      logic                  zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above & (val[4*k +: 4] == 4'h0);
         m[k]       = zero_above;
      end
      return m;
   endfunction
`endif

   logic                  w_tick;
   logic                  w_swap;
   logic                  w_take;
   digit_idx_t            w_dig_nxt;
   disp_word_t            w_disp_val_nxt;
   logic [NUM_DIGITS-1:0] w_disp_dp_nxt;
   logic                  w_dig_blank;
   logic [NUM_DIGITS-1:0] w_anode_nxt;

   digit_idx_t            r_dig;
   logic                  r_pending;
   logic                  r_frame_done;
   disp_word_t            r_shadow_val;
   logic [NUM_DIGITS-1:0] r_shadow_dp;
   disp_word_t            r_disp_val;
   logic [NUM_DIGITS-1:0] r_disp_dp;
   logic [3:0]            r_hex;
   logic [NUM_DIGITS-1:0] r_anode;
   logic                  r_dp;

   refresh_tick #(
      .TICK_DIV(TICK_DIV)
   ) u_refresh_tick (
      .clk  (clk),
      .reset(reset),
      .tick (w_tick)
   );

   // Frame boundary: end of digit 7's slot. The display copy is replaced
   // only if a load is waiting; the swap reads the pre-edge shadow, so a
   // load on this very cycle lands in the shadow for the next frame.
   assign w_swap         = w_tick && (r_dig == digit_idx_t'(NUM_DIGITS - 1));
   assign w_take         = w_swap && r_pending;
   assign w_dig_nxt      = w_tick ? digit_idx_t'(r_dig + 3'd1) : r_dig;
   assign w_disp_val_nxt = w_take ? r_shadow_val : r_disp_val;
   assign w_disp_dp_nxt  = w_take ? r_shadow_dp  : r_disp_dp;

`ifdef DISP_LZB_EN
   logic [NUM_DIGITS-1:0] r_blank;
   logic [NUM_DIGITS-1:0] w_blank_nxt;

   assign w_blank_nxt = w_take ? lzb_mask(r_shadow_val) : r_blank;
   assign w_dig_blank = w_blank_nxt[w_dig_nxt];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_blank <= lzb_mask('0);
      end else begin
         r_blank <= w_blank_nxt;
      end
   end
`else
   assign w_dig_blank = 1'b0;
`endif

   // Outputs are computed from next-state index/data so they are registered
   // yet already reflect the digit being entered. A tick forces the
   // anti-ghosting blank cycle.
   assign w_anode_nxt = (w_tick || w_dig_blank) ? ANODE_OFF
                                                : ~(8'b1 << w_dig_nxt);

   // ---- control state ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dig        <= '0;
         r_pending    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_dig        <= w_dig_nxt;
         r_pending    <= load | (r_pending & ~w_swap);
         r_frame_done <= w_swap;
      end
   end

   // ---- shadow and display buffers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
      end else begin
         if (load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_mask;
         end
         r_disp_val <= w_disp_val_nxt;
         r_disp_dp  <= w_disp_dp_nxt;
      end
   end

   // ---- registered display outputs ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hex   <= 4'h0;
         r_anode <= ANODE_OFF;
         r_dp    <= 1'b1;
      end else begin
         r_hex   <= w_disp_val_nxt[4*w_dig_nxt +: 4];
         r_anode <= w_anode_nxt;
         r_dp    <= ~w_disp_dp_nxt[w_dig_nxt] | w_dig_blank;
      end
   end

   assign hex        = r_hex;
   assign anode      = r_anode;
   assign dp         = r_dp;
   assign pending    = r_pending;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_display_scanner
// Directed bench for display_scanner with TICK_DIV=4 (32-cycle frame).
// Outputs are sampled on the falling edge; inputs are driven right after
// the sample so the next rising edge captures them. A frame walker checks
// anode/hex/dp/pending/frame_done on every cycle of a frame against
// hand-specified display contents. Build with DISP_LZB_EN for blanking.
// ---------------------------------------------------------------------------
module tb_display_scanner;

   localparam int TD = 4;

`ifdef DISP_LZB_EN
   localparam logic [7:0] BLK_ZERO = 8'hFE;
   localparam logic [7:0] BLK_42   = 8'hFC;
`else
   localparam logic [7:0] BLK_ZERO = 8'h00;
   localparam logic [7:0] BLK_42   = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [31:0] value;
   logic [7:0]  dp_mask;
   logic [3:0]  hex;
   logic [7:0]  anode;
   logic        dp;
   logic        pending;
   logic        frame_done;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic exp_pend;

   display_scanner #(
      .TICK_DIV(TD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .value     (value),
      .dp_mask   (dp_mask),
      .hex       (hex),
      .anode     (anode),
      .dp        (dp),
      .pending   (pending),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      cyc++;
   endtask

   // Walk one full frame starting at the blank cycle of digit 0.
   // ev/edp/eblk: expected display value, dp mask and blank mask.
   // efd: expected frame_done on the first cycle. la/lb: frame-relative
   // cycles on which to pulse load (-1 for none).
   task automatic run_frame(input logic [31:0] ev, input logic [7:0] edp,
                            input logic [7:0] eblk, input logic efd,
                            input int la, input logic [31:0] lva, input logic [7:0] lda,
                            input int lb, input logic [31:0] lvb, input logic [7:0] ldb);
      for (int i = 0; i < 32; i++) begin
         int         d;
         logic [7:0] e_an;
         logic [3:0] e_hex;
         logic       e_dp;
         logic       e_fd;
         d     = i / 4;
         e_an  = 8'h01 << d;
         e_an  = ((i % 4) == 0 || eblk[d]) ? 8'hFF : ~e_an;
         e_hex = ev[4*d +: 4];
         e_dp  = eblk[d] ? 1'b1 : ~edp[d];
         e_fd  = (i == 0) ? efd : 1'b0;
         chk("anode", anode, e_an);
         chk("hex", hex, e_hex);
         chk("dp", dp, e_dp);
         chk("pending", pending, exp_pend);
         chk("frame_done", frame_done, e_fd);
         if (i == la) begin
            load = 1'b1; value = lva; dp_mask = lda;
         end else if (i == lb) begin
            load = 1'b1; value = lvb; dp_mask = ldb;
         end else begin
            load = 1'b0;
         end
         if (load)         exp_pend = 1'b1;
         else if (i == 31) exp_pend = 1'b0;
         next_cyc();
      end
      load = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      load    = 1'b0;
      value   = '0;
      dp_mask = '0;
      repeat (2) @(negedge clk);

      // Reset state, then release.
      cyc      = 0;
      exp_pend = 1'b0;
      chk("rst_anode", anode, 8'hFF);
      chk("rst_hex", hex, 4'h0);
      chk("rst_dp", dp, 1'b1);
      chk("rst_pending", pending, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      reset = 1'b0;

      // Scan of the default value; load mid-frame in the second frame.
      run_frame(32'h0, 8'h00, BLK_ZERO, 1'b0, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00);
      run_frame(32'h0, 8'h00, BLK_ZERO, 1'b1, 8, 32'h1234_ABCD, 8'h01, -1, 32'h0, 8'h00);
      // Swapped value; two loads before the next swap (last wins).
      run_frame(32'h1234_ABCD, 8'h01, 8'h00, 1'b1, 4, 32'h1111_1111, 8'h00,
                20, 32'h2222_2222, 8'h00);
      // Shadow gets 5s, then Fs coincident with the digit-7 tick.
      run_frame(32'h2222_2222, 8'h00, 8'h00, 1'b1, 10, 32'h5555_5555, 8'h00,
                31, 32'hFFFF_FFFF, 8'hA5);
      run_frame(32'h5555_5555, 8'h00, 8'h00, 1'b1, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00);
      run_frame(32'hFFFF_FFFF, 8'hA5, 8'h00, 1'b1, 6, 32'h0000_0042, 8'h80,
                -1, 32'h0, 8'h00);
      // Leading-zero patterns (blanked only when DISP_LZB_EN is defined).
      run_frame(32'h0000_0042, 8'h80, BLK_42, 1'b1, 3, 32'h0000_0000, 8'h40,
                -1, 32'h0, 8'h00);
      run_frame(32'h0000_0000, 8'h40, BLK_ZERO, 1'b1, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00);

      // Reset during digit 3's slot with a load pending.
      load = 1'b1; value = 32'h89AB_CDEF; dp_mask = 8'hFF;
      next_cyc();
      load = 1'b0;
      repeat (13) next_cyc();
      chk("mid_anode_d3", anode, 8'hF7);
      chk("mid_pending", pending, 1'b1);
      reset = 1'b1;
      next_cyc();
      chk("mid_rst_anode", anode, 8'hFF);
      chk("mid_rst_pending", pending, 1'b0);
      chk("mid_rst_hex", hex, 4'h0);
      chk("mid_rst_dp", dp, 1'b1);
      chk("mid_rst_frame_done", frame_done, 1'b0);
      reset    = 1'b0;
      cyc      = 0;
      exp_pend = 1'b0;
      run_frame(32'h0, 8'h00, BLK_ZERO, 1'b0, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00);
      run_frame(32'h0, 8'h00, BLK_ZERO, 1'b1, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
